// File: rtl/score_pkg.sv
// Shared types and widths for the Pong score keeper.
package score_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam int SCOREW = 4;

endpackage

// File: rtl/score_keeper_frame_timer.sv
// Counts frame pulses; done fires combinationally on the pulse that reaches target.
module frame_timer #(
   parameter int FCNTW = 8
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   input  logic             clear,
   input  logic             frame,
   input  logic [FCNTW-1:0] target,
   output logic             done
);

   logic [FCNTW-1:0] cnt;
   logic [FCNTW-1:0] cnt_inc;

   assign cnt_inc = cnt + 1'b1;
   // clear wins over a coincident frame pulse, so that pulse is never counted
   assign done = frame && !clear && (cnt_inc == target);

   always_ff @(posedge clk_pix) begin
      if (rst_pix || clear) begin
         cnt <= '0;
      end else if (frame) begin
         cnt <= done ? '0 : cnt_inc;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Pong game-state controller: serve/play/point/over sequencing and saturating 0..WIN_SCORE scores.
module score_keeper
   import score_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int FCNTW        = 8
) (
   input  logic              clk_pix,
   input  logic              rst_pix,
   input  logic              frame,
   input  logic              start,
   input  logic              miss_l,
   input  logic              miss_r,
   output logic [SCOREW-1:0] score_l,
   output logic [SCOREW-1:0] score_r,
   output logic              play,
   output logic              serve_dir,
   output logic              game_over,
   output logic              winner,
   output logic [2:0]        state_dbg
);

   localparam logic [SCOREW-1:0] WIN = SCOREW'(WIN_SCORE);

   state_t           state;
   logic             entered;
   logic             timer_clear;
   logic             timer_done;
   logic [FCNTW-1:0] timer_target;

   // entered marks the first cycle of a state, which restarts the frame count
   assign timer_clear  = entered || !((state == SERVE) || (state == POINT));
   assign timer_target = (state == SERVE) ? FCNTW'(SERVE_FRAMES) : FCNTW'(POINT_FRAMES);
   assign state_dbg    = state;

   frame_timer #(.FCNTW(FCNTW)) u_timer (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .clear   (timer_clear),
      .frame   (frame),
      .target  (timer_target),
      .done    (timer_done)
   );

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         state     <= IDLE;
         entered   <= 1'b0;
         score_l   <= '0;
         score_r   <= '0;
         play      <= 1'b0;
         serve_dir <= 1'b0;
         game_over <= 1'b0;
         winner    <= 1'b0;
      end else begin
         entered <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SERVE;
                  entered <= 1'b1;
                  score_l <= '0;
                  score_r <= '0;
               end
            end
            SERVE: begin
               if (timer_done) begin
                  state   <= PLAY;
                  entered <= 1'b1;
                  play    <= 1'b1;
               end
            end
            PLAY: begin
               if (miss_l || miss_r) begin
                  state   <= POINT;
                  entered <= 1'b1;
                  play    <= 1'b0;
                  if (miss_l && miss_r) begin
                     serve_dir <= ~serve_dir;
                  end else if (miss_l) begin
                     serve_dir <= 1'b0;
                     if (score_r < WIN) score_r <= score_r + 1'b1;
                  end else begin
                     serve_dir <= 1'b1;
                     if (score_l < WIN) score_l <= score_l + 1'b1;
                  end
               end
            end
            POINT: begin
               if (timer_done) begin
                  entered <= 1'b1;
                  if ((score_l == WIN) || (score_r == WIN)) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                     winner    <= (score_r == WIN);
                  end else begin
                     state <= SERVE;
                  end
               end
            end
            OVER: begin
               if (start) begin
                  state     <= SERVE;
                  entered   <= 1'b1;
                  score_l   <= '0;
                  score_r   <= '0;
                  game_over <= 1'b0;
                  serve_dir <= ~winner;
               end
            end
            default: begin
               state   <= IDLE;
               entered <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Vector-table bench for score_keeper with SERVE_FRAMES=2, POINT_FRAMES=3, WIN_SCORE=3.
`timescale 1ns/1ps
module tb_score_keeper;
   import score_pkg::*;

   localparam int W = 15;

   logic       clk_pix = 1'b0;
   logic       rst_pix = 1'b0;
   logic       frame   = 1'b0;
   logic       start   = 1'b0;
   logic       miss_l  = 1'b0;
   logic       miss_r  = 1'b0;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic       play;
   logic       serve_dir;
   logic       game_over;
   logic       winner;
   logic [2:0] state_dbg;

   score_keeper #(
      .WIN_SCORE(3), .SERVE_FRAMES(2), .POINT_FRAMES(3), .FCNTW(8)
   ) dut (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .frame     (frame),
      .start     (start),
      .miss_l    (miss_l),
      .miss_r    (miss_r),
      .score_l   (score_l),
      .score_r   (score_r),
      .play      (play),
      .serve_dir (serve_dir),
      .game_over (game_over),
      .winner    (winner),
      .state_dbg (state_dbg)
   );

   // clock
   always #5 clk_pix = ~clk_pix;

   typedef struct {
      string        name;
      logic         rst;
      logic         start;
      logic         frame;
      logic         ml;
      logic         mr;
      logic [W-1:0] exp;
   } vec_t;

   vec_t         tbl[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mask_q[$];
   int           checks = 0;
   int           errors = 0;

   // exp layout: {state, score_l, score_r, play, serve_dir, game_over, winner}
   task automatic add(input string n, input logic r, input logic s, input logic f,
                      input logic ml, input logic mr, input logic [2:0] st,
                      input int sl, input int sr, input logic p, input logic sd,
                      input logic go, input logic w);
      vec_t v;
      v.name  = n;
      v.rst   = r;
      v.start = s;
      v.frame = f;
      v.ml    = ml;
      v.mr    = mr;
      v.exp   = {st, 4'(sl), 4'(sr), p, sd, go, w};
      tbl.push_back(v);
   endtask

   // first frame lands on the SERVE entry cycle and is not counted
   task automatic serve_seq(input int sl, input int sr, input logic sd);
      add("serve_entry", 0, 0, 1, 0, 0, SERVE, sl, sr, 0, sd, 0, 0);
      add("serve_f1",    0, 0, 1, 0, 0, SERVE, sl, sr, 0, sd, 0, 0);
      add("serve_f2",    0, 0, 1, 0, 0, PLAY,  sl, sr, 1, sd, 0, 0);
   endtask

   task automatic point_frames(input int sl, input int sr, input logic sd);
      add("point_f1", 0, 0, 1, 0, 0, POINT, sl, sr, 0, sd, 0, 0);
      add("point_f2", 0, 0, 1, 0, 0, POINT, sl, sr, 0, sd, 0, 0);
      add("point_f3", 0, 0, 1, 0, 0, SERVE, sl, sr, 0, sd, 0, 0);
   endtask

   task automatic check(input string n, input logic [W-1:0] act,
                        input logic [W-1:0] e, input logic [W-1:0] m);
      checks++;
      if ((act & m) !== (e & m)) begin
         errors++;
         $display("FAIL %s: act=%h exp=%h (mask %h)", n, act, e, m);
      end
   endtask

   function automatic logic [W-1:0] dut_out();
      return {state_dbg, score_l, score_r, play, serve_dir, game_over, winner};
   endfunction

   initial begin
      // build vector table
      add("reset",        1, 0, 0, 0, 0, IDLE,  0, 0, 0, 0, 0, 0);
      add("idle_frame",   0, 0, 1, 0, 0, IDLE,  0, 0, 0, 0, 0, 0);
      add("start",        0, 1, 0, 0, 0, SERVE, 0, 0, 0, 0, 0, 0);
      serve_seq(0, 0, 0);
      add("start_in_play",0, 1, 0, 0, 0, PLAY,  0, 0, 1, 0, 0, 0);
      add("miss_r",       0, 0, 0, 0, 1, POINT, 1, 0, 0, 1, 0, 0);
      add("miss_in_point",0, 0, 0, 1, 0, POINT, 1, 0, 0, 1, 0, 0);
      point_frames(1, 0, 1);
      serve_seq(1, 0, 1);
      add("miss_both",    0, 0, 0, 1, 1, POINT, 1, 0, 0, 0, 0, 0);
      add("miss_l_late",  0, 0, 0, 1, 0, POINT, 1, 0, 0, 0, 0, 0);
      point_frames(1, 0, 0);
      serve_seq(1, 0, 0);
      for (int k = 1; k <= 2; k++) begin
         add("miss_l",      0, 0, 0, 1, 0, POINT, 1, k, 0, 0, 0, 0);
         add("point_entry", 0, 0, 1, 0, 0, POINT, 1, k, 0, 0, 0, 0);
         point_frames(1, k, 0);
         serve_seq(1, k, 0);
      end
      add("miss_l_win",   0, 0, 0, 1, 0, POINT, 1, 3, 0, 0, 0, 0);
      add("point_entry",  0, 0, 1, 0, 0, POINT, 1, 3, 0, 0, 0, 0);
      add("win_f1",       0, 0, 1, 0, 0, POINT, 1, 3, 0, 0, 0, 0);
      add("win_f2",       0, 0, 1, 0, 0, POINT, 1, 3, 0, 0, 0, 0);
      add("start_point",  0, 1, 0, 0, 0, POINT, 1, 3, 0, 0, 0, 0);
      add("win_f3",       0, 0, 1, 0, 0, OVER,  1, 3, 0, 0, 1, 1);
      add("over_miss_l",  0, 0, 0, 1, 0, OVER,  1, 3, 0, 0, 1, 1);
      add("over_miss_r",  0, 0, 0, 0, 1, OVER,  1, 3, 0, 0, 1, 1);
      add("over_frame",   0, 0, 1, 0, 0, OVER,  1, 3, 0, 0, 1, 1);
      add("over_start",   0, 1, 0, 0, 0, SERVE, 0, 0, 0, 0, 0, 0);
      serve_seq(0, 0, 0);
      add("miss_r_a",     0, 0, 0, 0, 1, POINT, 1, 0, 0, 1, 0, 0);
      add("point_entry",  0, 0, 1, 0, 0, POINT, 1, 0, 0, 1, 0, 0);
      point_frames(1, 0, 1);
      serve_seq(1, 0, 1);
      add("miss_r_b",     0, 0, 0, 0, 1, POINT, 2, 0, 0, 1, 0, 0);
      add("point_entry",  0, 0, 1, 0, 0, POINT, 2, 0, 0, 1, 0, 0);
      add("point_f1",     0, 0, 1, 0, 0, POINT, 2, 0, 0, 1, 0, 0);
      add("rst_in_point", 1, 0, 0, 0, 0, IDLE,  0, 0, 0, 0, 0, 0);
      add("idle_after",   0, 0, 1, 0, 1, IDLE,  0, 0, 0, 0, 0, 0);
      add("restart",      0, 1, 0, 0, 0, SERVE, 0, 0, 0, 0, 0, 0);

      // apply table through the scoreboard; winner only matters in OVER or after reset
      @(posedge clk_pix);
      #1;
      foreach (tbl[i]) begin
         rst_pix = tbl[i].rst;
         start   = tbl[i].start;
         frame   = tbl[i].frame;
         miss_l  = tbl[i].ml;
         miss_r  = tbl[i].mr;
         exp_q.push_back(tbl[i].exp);
         mask_q.push_back((tbl[i].exp[1] || tbl[i].rst) ? {W{1'b1}} : {{(W-1){1'b1}}, 1'b0});
         @(posedge clk_pix);
         #1;
         check(tbl[i].name, dut_out(), exp_q.pop_front(), mask_q.pop_front());
      end
      rst_pix = 1'b0;
      start   = 1'b0;
      miss_l  = 1'b0;
      miss_r  = 1'b0;

      // continuous frame pulses from SERVE entry: play must rise on the third cycle
      begin
         int n;
         n = 0;
         frame = 1'b1;
         while (!play && n < 10) begin
            @(posedge clk_pix);
            #1;
            n++;
         end
         frame = 1'b0;
         checks++;
         if (n != 3) begin
            errors++;
            $display("FAIL serve_latency: cycles=%0d exp=3 play=%b", n, play);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
